tick_rate_controller: RTL and testbench

- Run-control and rate-selection controller for the lab's slow-clock generation.
- Replaces a free-running fixed divider with a controllable scheduler: start / stop / single-step / clear, four selectable periods.
- Emits a one-cycle enable pulse `tick` plus a 50% square `slow_clock` for downstream lab FSMs and displays.
- Sits directly on the 50 MHz board clock.

---
 rtl/tick_ctrl_pkg.sv | 49 ++++
 rtl/tick_rate_controller_if.sv | 36 +++
 rtl/tick_period_counter.sv | 43 ++++
 rtl/tick_rate_controller.sv | 163 ++++++++++++++++
 tb/tb_tick_rate_controller.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/tick_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tick_ctrl_pkg
// Shared types and constants for the tick rate controller.
//   state_t     : run-control FSM states (IDLE, RUN, PAUSE)
//   rate_sel_t  : 2-bit period selector
//   cmd_t       : decoded command, enumerated in ascending priority order
//   decode_cmd  : collapses the raw command inputs to the winning command
//   period_ok   : elaboration-time range check for a period constant
// ---------------------------------------------------------------------------
package tick_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef logic [1:0] rate_sel_t;

  localparam int DEFAULT_PERIOD_0          = 11_500_000;
  localparam int DEFAULT_PERIOD_1          = 25_000_000;
  localparam int DEFAULT_PERIOD_2          = 5_000_000;
  localparam int DEFAULT_PERIOD_3          = 50_000;
  localparam int DEFAULT_COUNT_WIDTH       = 26;
  localparam int DEFAULT_TICK_COUNT_WIDTH  = 8;

  // Encoded so that a larger value always wins: clear > stop > start > step.
  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_STEP  = 3'd1,
    CMD_START = 3'd2,
    CMD_STOP  = 3'd3,
    CMD_CLEAR = 3'd4
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic clear, input logic stop,
                                      input logic start, input logic step);
    if (clear)      return CMD_CLEAR;
    else if (stop)  return CMD_STOP;
    else if (start) return CMD_START;
    else if (step)  return CMD_STEP;
    else            return CMD_NONE;
  endfunction

  function automatic bit period_ok(input longint period, input int width);
    return (period >= 2) && (period < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/tick_rate_controller_if.sv
// ---------------------------------------------------------------------------
// tick_rate_controller_if
// Command / status bundle of the tick rate controller.
//   start, stop, step, clear : run-control commands (master -> slave)
//   rate_sel                 : period select (master -> slave)
//   tick                     : one-cycle enable pulse (slave -> master)
//   slow_clock               : square wave, toggles on every tick
//   running                  : high while the controller is in RUN
//   tick_count               : number of ticks issued, wraps
// ---------------------------------------------------------------------------
interface tick_rate_controller_if #(
  parameter int TICK_COUNT_WIDTH = tick_ctrl_pkg::DEFAULT_TICK_COUNT_WIDTH
) ();
  import tick_ctrl_pkg::*;

  logic                        start;
  logic                        stop;
  logic                        step;
  logic                        clear;
  rate_sel_t                   rate_sel;
  logic                        tick;
  logic                        slow_clock;
  logic                        running;
  logic [TICK_COUNT_WIDTH-1:0] tick_count;

  modport master (
    output start, stop, step, clear, rate_sel,
    input  tick, slow_clock, running, tick_count
  );

  modport slave (
    input  start, stop, step, clear, rate_sel,
    output tick, slow_clock, running, tick_count
  );

endinterface

// File: rtl/tick_period_counter.sv
// ---------------------------------------------------------------------------
// tick_period_counter
// Period counter for the tick scheduler.
//   clock, reset_n   : board clock, asynchronous active-low reset
//   i_load           : force the count to zero (highest priority)
//   i_hold           : freeze the count this cycle
//   i_enable         : count this cycle (the controller is in RUN)
//   i_period_active  : current period in clock cycles
//   o_wrap           : this edge completes a period; count returns to zero
// ---------------------------------------------------------------------------
module tick_period_counter #(
  parameter int COUNT_WIDTH = tick_ctrl_pkg::DEFAULT_COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   i_load,
  input  logic                   i_hold,
  input  logic                   i_enable,
  input  logic [COUNT_WIDTH-1:0] i_period_active,
  output logic                   o_wrap
);

  logic [COUNT_WIDTH-1:0] r_cnt;
  logic                   w_at_end;

  assign w_at_end = (r_cnt == i_period_active - COUNT_WIDTH'(1));
  // A load or hold in the same cycle suppresses the wrap, so a clear or stop
  // discards a period that would otherwise complete at this edge.
  assign o_wrap   = i_enable && !i_load && !i_hold && w_at_end;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_hold) begin
      r_cnt <= r_cnt;
    end else if (i_enable) begin
      r_cnt <= w_at_end ? '0 : r_cnt + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/tick_rate_controller.sv
// ---------------------------------------------------------------------------
// tick_rate_controller
// Run-control and rate-selection scheduler for the lab slow clock.
//   clock    : 50 MHz board clock
//   reset_n  : asynchronous active-low reset
//   bus      : tick_rate_controller_if.slave
//              in : start, stop, step, clear, rate_sel
//              out: tick, slow_clock, running, tick_count (all registered)
// The FSM (IDLE/RUN/PAUSE), the latched period, tick, slow_clock and
// tick_count live here; the period count lives in tick_period_counter.
// ---------------------------------------------------------------------------
module tick_rate_controller #(
  parameter int PERIOD_0         = tick_ctrl_pkg::DEFAULT_PERIOD_0,
  parameter int PERIOD_1         = tick_ctrl_pkg::DEFAULT_PERIOD_1,
  parameter int PERIOD_2         = tick_ctrl_pkg::DEFAULT_PERIOD_2,
  parameter int PERIOD_3         = tick_ctrl_pkg::DEFAULT_PERIOD_3,
  parameter int COUNT_WIDTH      = tick_ctrl_pkg::DEFAULT_COUNT_WIDTH,
  parameter int TICK_COUNT_WIDTH = tick_ctrl_pkg::DEFAULT_TICK_COUNT_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  tick_rate_controller_if.slave   bus
);
  import tick_ctrl_pkg::*;

  function automatic longint period_of(input int idx);
    case (idx)
      0:       return longint'(PERIOD_0);
      1:       return longint'(PERIOD_1);
      2:       return longint'(PERIOD_2);
      default: return longint'(PERIOD_3);
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_period_check
      if (!period_ok(period_of(gi), COUNT_WIDTH)) begin : g_bad
        $error("tick_rate_controller: a PERIOD_n is < 2 or does not fit in COUNT_WIDTH bits");
      end
    end
  endgenerate

  // Registered state and outputs
  state_t                      r_state;
  logic                        r_running;
  logic                        r_tick;
  logic                        r_slow_clock;
  logic [TICK_COUNT_WIDTH-1:0] r_tick_count;
  logic [COUNT_WIDTH-1:0]      r_period_active;

  // Next-state values and decode
  state_t                      w_state_next;
  logic                        w_tick_next;
  logic                        w_slow_clock_next;
  logic [TICK_COUNT_WIDTH-1:0] w_tick_count_next;
  logic [COUNT_WIDTH-1:0]      w_period_next;
  logic [COUNT_WIDTH-1:0]      w_sel_period;
  cmd_t                        w_cmd;
  logic                        w_load;
  logic                        w_hold;
  logic                        w_enable;
  logic                        w_wrap;
  logic                        w_issue;

  always_comb begin : rate_lookup
    w_sel_period = COUNT_WIDTH'(PERIOD_0);
    case (bus.rate_sel)
      2'd0:    w_sel_period = COUNT_WIDTH'(PERIOD_0);
      2'd1:    w_sel_period = COUNT_WIDTH'(PERIOD_1);
      2'd2:    w_sel_period = COUNT_WIDTH'(PERIOD_2);
      default: w_sel_period = COUNT_WIDTH'(PERIOD_3);
    endcase
  end

  // Counter controls depend only on the command and the current state, so the
  // wrap flag coming back from the counter never feeds into them.
  always_comb begin : cmd_decode
    w_cmd    = decode_cmd(bus.clear, bus.stop, bus.start, bus.step);
    w_enable = (r_state == ST_RUN);
    w_hold   = (w_cmd == CMD_STOP);
    w_load   = (w_cmd == CMD_CLEAR) ||
               ((w_cmd == CMD_START) && (r_state == ST_IDLE)) ||
               ((w_cmd == CMD_STEP)  && (r_state != ST_RUN));
  end

  tick_period_counter #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_counter (
    .clock           (clock),
    .reset_n         (reset_n),
    .i_load          (w_load),
    .i_hold          (w_hold),
    .i_enable        (w_enable),
    .i_period_active (r_period_active),
    .o_wrap          (w_wrap)
  );

  always_comb begin : next_state
    w_state_next      = r_state;
    w_period_next     = r_period_active;
    w_slow_clock_next = r_slow_clock;
    w_tick_count_next = r_tick_count;
    w_issue           = 1'b0;

    case (w_cmd)
      CMD_CLEAR: begin
        w_state_next      = ST_IDLE;
        w_period_next     = COUNT_WIDTH'(PERIOD_0);
        w_slow_clock_next = 1'b0;
        w_tick_count_next = '0;
      end
      CMD_STOP: begin
        if (r_state == ST_RUN) w_state_next = ST_PAUSE;
      end
      CMD_START: begin
        // Resuming from PAUSE keeps the partially elapsed period.
        if (r_state == ST_IDLE) w_period_next = w_sel_period;
        w_state_next = ST_RUN;
      end
      CMD_STEP: begin
        if (r_state != ST_RUN) w_issue = 1'b1;
      end
      default: ;
    endcase

    // rate_sel is only sampled into the active period at a wrap.
    if (w_wrap) begin
      w_issue       = 1'b1;
      w_period_next = w_sel_period;
    end

    if (w_issue) begin
      w_slow_clock_next = ~r_slow_clock;
      w_tick_count_next = r_tick_count + TICK_COUNT_WIDTH'(1);
    end
    w_tick_next = w_issue;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_running       <= 1'b0;
      r_tick          <= 1'b0;
      r_slow_clock    <= 1'b0;
      r_tick_count    <= '0;
      r_period_active <= COUNT_WIDTH'(PERIOD_0);
    end else begin
      r_state         <= w_state_next;
      r_running       <= (w_state_next == ST_RUN);
      r_tick          <= w_tick_next;
      r_slow_clock    <= w_slow_clock_next;
      r_tick_count    <= w_tick_count_next;
      r_period_active <= w_period_next;
    end
  end

  assign bus.tick       = r_tick;
  assign bus.slow_clock = r_slow_clock;
  assign bus.running    = r_running;
  assign bus.tick_count = r_tick_count;

endmodule

// File: tb/tb_tick_rate_controller.sv
module tb_tick_rate_controller;
  import tick_ctrl_pkg::*;

  localparam int TCW = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  tick_rate_controller_if #(.TICK_COUNT_WIDTH(TCW)) bus ();

  tick_rate_controller #(
    .PERIOD_0         (4),
    .PERIOD_1         (6),
    .PERIOD_2         (3),
    .PERIOD_3         (2),
    .COUNT_WIDTH      (26),
    .TICK_COUNT_WIDTH (TCW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic           tick;
    logic           slow;
    logic           running;
    logic [TCW-1:0] count;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   periods [4] = '{4, 6, 3, 2};

  // Reference model state
  state_t         m_state;
  int             m_cnt;
  int             m_per;
  logic           m_tick;
  logic           m_slow;
  logic [TCW-1:0] m_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = ST_IDLE;
    m_cnt   = 0;
    m_per   = periods[0];
    m_tick  = 1'b0;
    m_slow  = 1'b0;
    m_count = '0;
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    bit issue;
    issue = 1'b0;
    if (bus.clear) begin
      m_state = ST_IDLE; m_cnt = 0; m_per = periods[0];
      m_slow = 1'b0; m_count = '0;
    end else if (bus.stop) begin
      if (m_state == ST_RUN) m_state = ST_PAUSE;
    end else if (bus.start && m_state != ST_RUN) begin
      if (m_state == ST_IDLE) begin
        m_cnt = 0;
        m_per = periods[bus.rate_sel];
      end
      m_state = ST_RUN;
    end else if (bus.step && m_state != ST_RUN) begin
      m_cnt = 0;
      issue = 1'b1;
    end else if (m_state == ST_RUN) begin
      if (m_cnt + 1 == m_per) begin
        m_cnt = 0;
        m_per = periods[bus.rate_sel];
        issue = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    m_tick = issue;
    if (issue) begin
      m_slow  = ~m_slow;
      m_count = m_count + 1'b1;
    end
  endtask

  // One clock: push the prediction, take the edge, pop and compare.
  task automatic cycle();
    exp_t e;
    model_step();
    e = '{tick: m_tick, slow: m_slow, running: (m_state == ST_RUN), count: m_count};
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    chk("sb_tick",    bus.tick,       e.tick);
    chk("sb_slow",    bus.slow_clock, e.slow);
    chk("sb_running", bus.running,    e.running);
    chk("sb_count",   bus.tick_count, e.count);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_tick"},    bus.tick,       0);
    chk({tag, "_slow"},    bus.slow_clock, 0);
    chk({tag, "_running"}, bus.running,    0);
    chk({tag, "_count"},   bus.tick_count, 0);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;
    all_zero("clear");
  endtask

  initial begin
    int ticks;
    bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0; bus.clear = 1'b0;
    bus.rate_sel = 2'd0;
    model_reset();

    // Asynchronous reset: outputs settle without a clock edge
    #2 reset_n = 1'b0;
    #1 all_zero("reset");
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cycle();
    $display("step reset: idle after reset");

    // Basic run at rate 0 (period 4)
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    chk("run_running_e0", bus.running, 1);
    for (int e = 1; e <= 12; e++) begin
      cycle();
      chk("run_tick", bus.tick, (e % 4 == 0));
      if (e % 4 == 0) chk("run_count", bus.tick_count, e / 4);
      if (e == 4) chk("run_slow_e4", bus.slow_clock, 1);
      if (e == 8) chk("run_slow_e8", bus.slow_clock, 0);
    end
    $display("step basic run: tick_count=%0d", bus.tick_count);

    // Rate change mid-period takes effect only at the next wrap
    do_clear();
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 5) bus.rate_sel = 2'd1;
      cycle();
      chk("rate_tick", bus.tick, (e == 4 || e == 8 || e == 14 || e == 20));
    end
    $display("step rate change: tick_count=%0d", bus.tick_count);

    // Pause and resume
    do_clear();
    bus.rate_sel = 2'd0;
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      bus.stop  = (e == 6);
      bus.start = (e == 16);
      cycle();
      if (e >= 6 && e <= 15) chk("pause_running", bus.running, 0);
      chk("pause_tick", bus.tick, (e == 4 || e == 19));
      if (e == 19) chk("pause_count", bus.tick_count, 2);
    end
    bus.stop = 1'b0; bus.start = 1'b0;
    $display("step pause/resume: tick_count=%0d", bus.tick_count);

    // Single-step in IDLE, then step ignored while running
    do_clear();
    for (int e = 0; e <= 7; e++) begin
      bus.step = (e == 2 || e == 5);
      cycle();
      chk("step_tick", bus.tick, (e == 2 || e == 5));
      chk("step_running", bus.running, 0);
    end
    bus.step = 1'b0;
    chk("step_count", bus.tick_count, 2);
    chk("step_slow", bus.slow_clock, 0);
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    cycle(); cycle();
    bus.step = 1'b1; cycle(); bus.step = 1'b0;
    chk("step_run_tick", bus.tick, 0);
    chk("step_run_count", bus.tick_count, 2);
    cycle();
    chk("step_run_wrap_tick", bus.tick, 1);
    chk("step_run_wrap_count", bus.tick_count, 3);
    $display("step single-step: tick_count=%0d", bus.tick_count);

    // Priority: start+stop in RUN pauses; clear+step in PAUSE clears silently
    bus.start = 1'b1; bus.stop = 1'b1; cycle(); bus.start = 1'b0; bus.stop = 1'b0;
    chk("prio_start_stop_running", bus.running, 0);
    bus.clear = 1'b1; bus.step = 1'b1; cycle(); bus.clear = 1'b0; bus.step = 1'b0;
    all_zero("prio_clear_step");
    $display("step priority: running=%0d tick_count=%0d", bus.running, bus.tick_count);

    // Asynchronous reset in the middle of a RUN cycle
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    for (int e = 1; e <= 5; e++) cycle();
    chk("pre_rst_running", bus.running, 1);
    chk("pre_rst_count", bus.tick_count, 1);
    #3 reset_n = 1'b0;
    #1 all_zero("midrun_reset");
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int e = 0; e < 3; e++) cycle();
    chk("post_rst_running", bus.running, 0);
    $display("step async reset: running=%0d", bus.running);

    // Counter wrap at the fastest rate: 512 cycles -> 256 ticks
    bus.rate_sel = 2'd3;
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    ticks = 0;
    for (int e = 1; e <= 512; e++) begin
      cycle();
      if (bus.tick === 1'b1) ticks++;
    end
    chk("wrap_ticks", ticks, 256);
    chk("wrap_count", bus.tick_count, 0);
    chk("wrap_slow", bus.slow_clock, 0);
    $display("step wrap: ticks=%0d tick_count=%0d", ticks, bus.tick_count);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
